dm_stage: RTL and testbench
===========================

Name: dm_stage

Overview:
- Data-memory stage directly downstream of the ALU in the single-cycle 10-instruction CPU.
- Consumes the ALU `result` as the effective address and `rt_out` as store data.
- Performs word, half and byte loads and stores.
- Returns load data to the register-file write-back mux.
- Flags misaligned or out-of-range accesses.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words (1024 words = 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0. Accesses outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2) are out of range.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data (rt_out).
- mem_write  input  1  store enable for this cycle.
- mem_read  input  1  load enable for this cycle.
- size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as error).
- load_unsigned  input  1  1 = zero-extend byte/half loads, 0 = sign-extend.
- rdata  output  32  load data, combinational, extended per size/load_unsigned.
- addr_err  output  1  sticky error flag, registered.
- err_addr  output  32  address of the first faulting access since reset, registered.

Behaviour:
- Reset (reset = 0, asynchronous):
  - every memory word = 0
  - addr_err = 0
  - err_addr = 0
  - rdata reads 0 because the memory is cleared
- Index and lane: word index = (addr - BASE_ADDR)[DEPTH_LOG2+1:2]; byte lane = addr[1:0].
- Access error (combinational, `fault`) when (mem_read | mem_write) and any of:
  - size = 3
  - size = 1 with addr[0] = 1
  - size = 2 with addr[1:0] != 0
  - address out of range
- Stores (mem_write = 1 and fault = 0) take effect at the rising edge, one write per cycle:
  - word: whole word = wdata
  - half: lane 0 writes bits [15:0], lane 2 writes bits [31:16], both from wdata[15:0]
  - byte: writes byte lane addr[1:0] from wdata[7:0]
  - unselected bytes are preserved
- Faulting store: memory unchanged.
- Loads: rdata is combinational from the current memory contents. Read-during-write in the same cycle returns the OLD data; the new data is visible the next cycle.
  - byte: selected lane, extended to 32 bits
  - half: selected lane, extended to 32 bits
  - word: raw 32-bit word
- rdata = 0 when mem_read = 0, or when the load faults.
- Error capture at the rising edge when fault = 1:
  - if addr_err = 0: addr_err <= 1 and err_addr <= addr
  - if addr_err = 1: both hold (first fault wins)
  - cleared only by reset
- mem_read and mem_write both high: store follows the store rules; rdata shows the pre-store value.
- Reset asserted mid-cycle: clears immediately; a store in that cycle is lost.

Optional Feature:
- Macro DM_TRACE_EN.
- Defined: simulation-only `$display` on every committed store at the clock edge, printing time, addr, size and the resulting word (MARS-compatible format: `@addr: data`), plus a display on each new fault.
- Undefined: no display code compiled; functional behaviour identical.

Decomposition:
- Shared package `cpu_defs`: SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2 constants.
- The ALU op encodings also live in `cpu_defs`.
- One natural sub-module, `dm_load_ext`: combinational lane select plus sign/zero extension (word, lane, size, load_unsigned -> rdata), reusable by a future I/O bridge.
- Byte-enable generation and error capture stay in dm_stage.

Test Plan:
- Reset, then word load at 0x0 -> rdata = 0, addr_err = 0.
- Store word 0x8765_4321 @0x10, then loads @0x10:
  - byte lane 3, signed -> 0xFFFF_FF87
  - byte lane 3, unsigned -> 0x0000_0087
  - half lane 0, signed -> 0x0000_4321
- Store byte 0xAB @0x12 over 0x8765_4321 -> word @0x10 reads 0x87AB_4321; other words unchanged.
- Store half @0x13 -> memory unchanged, addr_err = 1, err_addr = 0x13. A later word load @0x1002 (out of range) keeps err_addr = 0x13 and returns rdata = 0.
- Same-cycle read+write word @0x20 (old 0x1, new 0x2) -> rdata = 0x1 that cycle, 0x2 the next.
- Assert reset between edges after stores -> all outputs and memory words = 0 immediately; a store coinciding with reset is not retained.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: memory access-size codes and ALU operation encodings.
package cpu_defs;

   // Access-size encoding carried on the data-memory 'size' input
   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;
   localparam logic [1:0] SIZE_RSVD = 2'd3;

   // ALU operation encodings of the 10-instruction CPU
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_LUI  = 4'd8,
      ALU_PASS = 4'd9
   } alu_op_t;

   // Extend a byte to 32 bits, zero- or sign-filled
   function automatic logic [31:0] ext8(input logic [7:0] b, input logic zext);
      ext8 = zext ? {24'd0, b} : {{24{b[7]}}, b};
   endfunction

   // Extend a half-word to 32 bits, zero- or sign-filled
   function automatic logic [31:0] ext16(input logic [15:0] h, input logic zext);
      ext16 = zext ? {16'd0, h} : {{16{h[15]}}, h};
   endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension: picks the addressed byte or
// half-word out of a 32-bit memory word and extends it to 32 bits.
// Reserved size codes return zero.
module dm_load_ext
   import cpu_defs::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_load_unsigned,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the addressed byte and half-word lanes
   always_comb begin
      w_byte = 8'd0;
      case (i_lane)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         2'd3:    w_byte = i_word[31:24];
         default: w_byte = 8'd0;
      endcase
      if (i_lane[1]) begin
         w_half = i_word[31:16];
      end else begin
         w_half = i_word[15:0];
      end
   end

   // Extend the selected lane according to access size
   always_comb begin
      o_rdata = 32'd0;
      case (i_size)
         SIZE_BYTE: o_rdata = ext8(w_byte, i_load_unsigned);
         SIZE_HALF: o_rdata = ext16(w_half, i_load_unsigned);
         SIZE_WORD: o_rdata = i_word;
         default:   o_rdata = 32'd0;
      endcase
   end

endmodule

// File: rtl/dm_stage.sv
// Data-memory stage: word/half/byte loads and stores against a cleared-on-reset
// word array, with a sticky first-fault capture of misaligned or
// out-of-range accesses. Loads are combinational and see pre-store data.
// Optional build macro: DM_TRACE_EN adds simulation store/fault trace output.
module dm_stage
   import cpu_defs::*;
#(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_write,
   input  logic        mem_read,
   input  logic [1:0]  size,
   input  logic        load_unsigned,
   output logic [31:0] rdata,
   output logic        addr_err,
   output logic [31:0] err_addr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0]           r_mem [DEPTH];
   logic                  r_addr_err;
   logic [31:0]           r_err_addr;

   logic [31:0]           w_offset;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [1:0]            w_lane;
   logic                  w_in_range;
   logic                  w_bad_size;
   logic                  w_fault;
   logic                  w_store;
   logic [3:0]            w_be;
   logic [31:0]           w_wrep;
   logic [31:0]           w_cur_word;
   logic [31:0]           w_new_word;
   logic [31:0]           w_ext;

   // Address decode: word index, lane, range and alignment checks
   always_comb begin
      w_offset   = addr - BASE_ADDR;
      w_idx      = w_offset[DEPTH_LOG2+1:2];
      w_lane     = addr[1:0];
      // Addresses below BASE_ADDR wrap to a huge offset and fail here too
      w_in_range = ((w_offset >> (DEPTH_LOG2 + 2)) == 32'd0);
      w_bad_size = 1'b0;
      case (size)
         SIZE_BYTE: w_bad_size = 1'b0;
         SIZE_HALF: w_bad_size = addr[0];
         SIZE_WORD: w_bad_size = (addr[1:0] != 2'd0);
         default:   w_bad_size = 1'b1;
      endcase
      w_fault = (mem_read | mem_write) & (w_bad_size | ~w_in_range);
      w_store = mem_write & ~w_fault;
   end

   // Byte enables and lane-replicated store data
   always_comb begin
      w_be   = 4'b0000;
      w_wrep = wdata;
      case (size)
         SIZE_BYTE: begin
            w_be   = 4'b0001 << w_lane;
            w_wrep = {4{wdata[7:0]}};
         end
         SIZE_HALF: begin
            w_be   = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wrep = {2{wdata[15:0]}};
         end
         SIZE_WORD: begin
            w_be   = 4'b1111;
            w_wrep = wdata;
         end
         default: begin
            w_be   = 4'b0000;
            w_wrep = wdata;
         end
      endcase
   end

   // Merge enabled store bytes into the currently stored word
   always_comb begin
      w_cur_word = r_mem[w_idx];
      w_new_word = w_cur_word;
      for (int b = 0; b < 4; b++) begin
         if (w_be[b]) begin
            w_new_word[8*b +: 8] = w_wrep[8*b +: 8];
         end else begin
            w_new_word[8*b +: 8] = w_cur_word[8*b +: 8];
         end
      end
   end

   // Memory array: cleared on reset, one merged word write per cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 32'd0;
         end
      end else if (w_store) begin
         r_mem[w_idx] <= w_new_word;
      end
   end

   // Sticky error capture: first faulting address since reset wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr_err <= 1'b0;
         r_err_addr <= 32'd0;
      end else if (w_fault && !r_addr_err) begin
         r_addr_err <= 1'b1;
         r_err_addr <= addr;
      end
   end

   dm_load_ext u_load_ext (
      .i_word          (w_cur_word),
      .i_lane          (w_lane),
      .i_size          (size),
      .i_load_unsigned (load_unsigned),
      .o_rdata         (w_ext)
   );

   // Load data is gated to zero when not reading or when the access faults
   always_comb begin
      if (mem_read && !w_fault) begin
         rdata = w_ext;
      end else begin
         rdata = 32'd0;
      end
   end

   assign addr_err = r_addr_err;
   assign err_addr = r_err_addr;

`ifdef DM_TRACE_EN
   // Simulation trace of committed stores and faulting accesses
   always @(posedge clk) begin
      if (reset) begin
         if (w_store) begin
            $display("%0t dm_stage store size=%0d @%08h: %08h", $time, size, addr, w_new_word);
         end
         if (w_fault) begin
            $display("%0t dm_stage fault addr=%08h size=%0d rd=%0b wr=%0b",
                     $time, addr, size, mem_read, mem_write);
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_dm_stage.sv
// Directed self-checking bench for dm_stage.
module tb_dm_stage;
   import cpu_defs::*;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_write;
   logic        mem_read;
   logic [1:0]  size;
   logic        load_unsigned;
   logic [31:0] rdata;
   logic        addr_err;
   logic [31:0] err_addr;

   int n_tests;
   int n_fail;

   dm_stage dut (
      .clk           (clk),
      .reset         (reset),
      .addr          (addr),
      .wdata         (wdata),
      .mem_write     (mem_write),
      .mem_read      (mem_read),
      .size          (size),
      .load_unsigned (load_unsigned),
      .rdata         (rdata),
      .addr_err      (addr_err),
      .err_addr      (err_addr)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog bound on the whole run
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Apply one access at the falling edge and settle
   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic r, input logic [1:0] s, input logic u);
      @(negedge clk);
      addr = a; wdata = d; mem_write = w; mem_read = r; size = s; load_unsigned = u;
      #1;
   endtask

   // One committed store, then idle the bus
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      drive(a, d, 1'b1, 1'b0, s, 1'b0);
      @(posedge clk);
      #1;
      mem_write = 1'b0;
   endtask

   // Combinational load followed by a check of rdata
   task automatic load_chk(input string tag, input logic [31:0] a, input logic [1:0] s,
                           input logic u, input logic [31:0] exp);
      drive(a, 32'd0, 1'b0, 1'b1, s, u);
      check_val(tag, rdata, exp);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b0;
      addr = 32'd0; wdata = 32'd0; mem_write = 1'b0; mem_read = 1'b1;
      size = SIZE_WORD; load_unsigned = 1'b0;
      #1;
      check_val("rst_addr_err", {31'd0, addr_err}, 32'd0);
      check_val("rst_err_addr", err_addr, 32'd0);
      check_val("rst_rdata", rdata, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      load_chk("ld_w_0", 32'h0, SIZE_WORD, 1'b0, 32'h0);
      check_val("addr_err_0", {31'd0, addr_err}, 32'd0);

      // Word store then lane loads
      do_store(32'h10, 32'h8765_4321, SIZE_WORD);
      load_chk("ld_w_10",    32'h10, SIZE_WORD, 1'b0, 32'h8765_4321);
      load_chk("ld_b3_s",    32'h13, SIZE_BYTE, 1'b0, 32'hFFFF_FF87);
      load_chk("ld_b3_u",    32'h13, SIZE_BYTE, 1'b1, 32'h0000_0087);
      load_chk("ld_h0_s",    32'h10, SIZE_HALF, 1'b0, 32'h0000_4321);
      load_chk("ld_h2_s",    32'h12, SIZE_HALF, 1'b0, 32'hFFFF_8765);
      load_chk("ld_h2_u",    32'h12, SIZE_HALF, 1'b1, 32'h0000_8765);
      load_chk("ld_b1_s",    32'h11, SIZE_BYTE, 1'b0, 32'h0000_0043);

      // Byte store uses only wdata[7:0] and preserves other lanes
      do_store(32'h12, 32'hFFFF_FFAB, SIZE_BYTE);
      load_chk("ld_w_after_b", 32'h10, SIZE_WORD, 1'b0, 32'h87AB_4321);
      load_chk("ld_w_14",      32'h14, SIZE_WORD, 1'b0, 32'h0);
      load_chk("ld_w_0c",      32'h0C, SIZE_WORD, 1'b0, 32'h0);

      // Upper half store at lane 2
      do_store(32'h16, 32'h1234_BEEF, SIZE_HALF);
      load_chk("ld_w_14_h", 32'h14, SIZE_WORD, 1'b0, 32'hBEEF_0000);

      // Last in-range word
      do_store(32'hFFC, 32'h5A5A_A5A5, SIZE_WORD);
      load_chk("ld_w_ffc", 32'hFFC, SIZE_WORD, 1'b0, 32'h5A5A_A5A5);
      check_val("no_err_yet", {31'd0, addr_err}, 32'd0);

      // Misaligned half store: memory unchanged, error captured
      do_store(32'h13, 32'h0000_BEEF, SIZE_HALF);
      check_val("err_set", {31'd0, addr_err}, 32'd1);
      check_val("err_addr_13", err_addr, 32'h13);
      load_chk("ld_w_10_keep", 32'h10, SIZE_WORD, 1'b0, 32'h87AB_4321);

      // Out-of-range load returns zero, first fault is kept
      load_chk("ld_oor", 32'h1002, SIZE_WORD, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      check_val("err_hold", err_addr, 32'h13);
      check_val("err_still", {31'd0, addr_err}, 32'd1);
      load_chk("ld_rsvd", 32'h10, SIZE_RSVD, 1'b0, 32'h0);
      // Store just past the end must not alias onto word 0
      do_store(32'h1000, 32'hCAFE_F00D, SIZE_WORD);
      load_chk("ld_w_0_noalias", 32'h0, SIZE_WORD, 1'b0, 32'h0);

      // Read-during-write returns old data, new data next cycle
      do_store(32'h20, 32'h1, SIZE_WORD);
      drive(32'h20, 32'h2, 1'b1, 1'b1, SIZE_WORD, 1'b0);
      check_val("rdw_old", rdata, 32'h1);
      drive(32'h20, 32'h0, 1'b0, 1'b1, SIZE_WORD, 1'b0);
      check_val("rdw_new", rdata, 32'h2);

      // Reset asserted between edges while a store is pending
      drive(32'h30, 32'hDEAD_BEEF, 1'b1, 1'b0, SIZE_WORD, 1'b0);
      #1;
      reset = 1'b0;
      #1;
      check_val("mid_rst_err", {31'd0, addr_err}, 32'd0);
      check_val("mid_rst_eaddr", err_addr, 32'd0);
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      mem_read  = 1'b1;
      addr      = 32'h10;
      #1;
      check_val("mid_rst_rd10", rdata, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      load_chk("post_rst_30",  32'h30,  SIZE_WORD, 1'b0, 32'h0);
      load_chk("post_rst_20",  32'h20,  SIZE_WORD, 1'b0, 32'h0);
      load_chk("post_rst_ffc", 32'hFFC, SIZE_WORD, 1'b0, 32'h0);
      load_chk("post_rst_14",  32'h14,  SIZE_WORD, 1'b0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
